rom_step_ctrl: RTL
==================

# rom_step_ctrl

Sequencing controller for the instruction-ROM address that feeds the instruction memory and the seven-segment debug display. It replaces a free-running address counter with a small state machine. The address can free-run at a selectable tick rate, be single-stepped from a debounced push-button, or halt on a breakpoint address. All activity is in the single system clock domain; ticks are derived internally from a free-running divider, with no derived clocks.

## Interface
Parameters:
- ADDR_W, 6: width of the ROM address.
- ROM_NUM, 23: last valid address; the address wraps from ROM_NUM to 0.
- DIV_FAST, 24: divider bit index used for ticks when tick_sel=0.
- DIV_SLOW, 25: divider bit index used for ticks when tick_sel=1.
- DEB_CNT, 1000000: number of consecutive stable cycles required to accept a new button level.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- tick_sel  in  1  tick rate select (0 = DIV_FAST, 1 = DIV_SLOW).
- run_en  in  1  level input; 1 requests free-run.
- step_btn  in  1  raw asynchronous push-button, active-high.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint address.
- rom_addr  out  ADDR_W  current ROM address (registered).
- adv_o  out  1  one-cycle pulse, high in the first cycle a new rom_addr is visible.
- state_o  out  2  encoded FSM state.
- halted_o  out  1  high while in HALT.

## Operation
- Divider: a 32-bit counter increments every cycle. The selected bit is registered into sel_q every cycle. tick = sel_bit & ~sel_q, a one-cycle pulse on each rising transition of the selected bit.
- A tick_sel change can produce at most one extra tick. This is accepted behaviour.
- Button path:
  - A 2-flop synchronizer feeds a debounce counter.
  - The debounced level updates only after DEB_CNT consecutive cycles in which the synchronized level differs from it; any agreement resets the counter.
  - step_pulse is a one-cycle pulse on the 0→1 edge of the debounced level.
- Advance: rom_addr ← (rom_addr == ROM_NUM) ? 0 : rom_addr + 1. Values above ROM_NUM cannot occur.
- FSM states (state_o): IDLE=00, RUN=01, STEP=10, HALT=11.
  - IDLE: run_en=1 → RUN. Otherwise step_pulse → STEP, with the address advanced on that edge. Ticks are ignored.
  - STEP: lasts one cycle, then returns to IDLE unconditionally. It exists so that state_o shows the step.
  - RUN: each tick advances the address.
    - If bp_en=1 and the next address equals bp_addr, the advance still happens and the FSM enters HALT on the same edge.
    - run_en=0 → IDLE; this takes priority over a same-cycle tick, so no advance occurs.
    - step_pulse is ignored.
  - HALT: the address is frozen. run_en=0 → IDLE. Ticks and steps are ignored.
- The breakpoint fires only on arrival at bp_addr. Entering RUN while already at bp_addr does not halt.
- A step in IDLE does not check the breakpoint.

## Timing
- Reset values:
  - rom_addr=0, adv_o=0, state_o=IDLE, halted_o=0.
  - Divider=0, sel_q=0, debounced level=0, debounce counter=0, synchronizer flops=0.
- Reset is asynchronous at assertion, so all outputs change immediately. Deassertion is synchronous to the next clk edge through the normal flops.
- Reset mid-RUN or mid-debounce discards all progress.
- Tick latency: tick high in cycle N → rom_addr updates at the end of N and adv_o is high in N+1.
- Button latency: step_pulse occurs 2 + DEB_CNT cycles after step_btn stably rises. The address updates 1 cycle later, and adv_o is high in the cycle after that update edge.
- run_en is sampled every cycle, and an IDLE→RUN transition takes one edge. A tick coincident with the IDLE→RUN edge does not advance.
- halted_o is registered and rises on the same edge as the breakpoint advance.

## Test plan
Bench parameters: ADDR_W=6, ROM_NUM=5, DIV_FAST=2, DIV_SLOW=3, DEB_CNT=4, bp_en=0 unless stated.
- Free-run wrap: hold run_en=1 with tick_sel=0 → rom_addr steps 1,2,3,4,5,0,1 with one step every 8 cycles. adv_o is a single-cycle pulse at each change.
- Rate select: tick_sel=1 with run_en=1 → the advance period becomes 16 cycles. Switching tick_sel mid-run yields at most one extra advance.
- Debounce: with the FSM in IDLE, toggle step_btn every 2 cycles for 20 cycles, then hold it high → exactly one advance. The advance occurs 2+4+1 cycles after the stable rise. state_o shows 10 for one cycle.
- Breakpoint: bp_en=1, bp_addr=3, run_en=1 from addr 0 → addr reaches 3, then halted_o=1 and state_o=11. Addr holds at 3 through further ticks and button presses. Dropping run_en → IDLE, halted_o=0. Reasserting run_en → continues to 4 without re-halting.
- Simultaneous events: drop run_en in the same cycle as a tick → no advance, state IDLE. Press the step button during RUN → ignored.
- Async reset: assert rstn=0 mid-RUN at addr 4, between clock edges → rom_addr=0 and state_o=00 immediately. After release, no advance until run_en or a step occurs.

Source files
------------

// File: rtl/rom_step_ctrl.sv
// Instruction-ROM address sequencer: free-run on divided ticks, single-step from a
// debounced push-button, or halt on arrival at a breakpoint address.
module rom_step_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int ROM_NUM  = 23,
  parameter int DIV_FAST = 24,
  parameter int DIV_SLOW = 25,
  parameter int DEB_CNT  = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick_sel,
  input  logic              run_en,
  input  logic              step_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              adv_o,
  output logic [1:0]        state_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_e;

  localparam int CNT_W = $clog2(DEB_CNT + 1);

  logic [31:0]       div_q;
  logic [31:0]       div_d;
  logic              sel_q;
  logic              sel_bit;
  logic              tick;

  logic [1:0]        sync_q;
  logic              deb_q;
  logic              deb_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              step_pulse_q;
  logic              step_pulse_d;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic              adv_q;
  logic              halted_q;

  // Tick is the rising transition of the selected divider bit; a tick_sel flip can
  // therefore look like one extra rising edge, which is tolerated.
  assign div_d   = div_q + 32'd1;
  assign sel_bit = tick_sel ? div_q[DIV_SLOW] : div_q[DIV_FAST];
  assign tick    = sel_bit & ~sel_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
      sel_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sel_q <= sel_bit;
    end
  end

  // Debounce: accept a new level only after DEB_CNT consecutive disagreeing cycles.
  always_comb begin
    deb_d        = deb_q;
    cnt_d        = '0;
    step_pulse_d = 1'b0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
        deb_d        = sync_q[1];
        step_pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q       <= 2'b00;
      deb_q        <= 1'b0;
      cnt_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], step_btn};
      deb_q        <= deb_d;
      cnt_q        <= cnt_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign addr_inc = (addr_q == ADDR_W'(ROM_NUM)) ? '0 : addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      adv_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      adv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_en) begin
            state_q <= RUN;
          end else if (step_pulse_q) begin
            state_q <= STEP;
            addr_q  <= addr_inc;
            adv_q   <= 1'b1;
          end
        end
        STEP: state_q <= IDLE;
        RUN: begin
          // Dropping run_en wins over a coincident tick.
          if (!run_en) begin
            state_q <= IDLE;
          end else if (tick) begin
            addr_q <= addr_inc;
            adv_q  <= 1'b1;
            if (bp_en && (addr_inc == bp_addr)) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end
        end
        HALT: begin
          if (!run_en) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign adv_o    = adv_q;
  assign state_o  = state_q;
  assign halted_o = halted_q;

endmodule
